// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter.
// Requester ID encodings, SRAM-like size encodings, the FIFO entry payload,
// the downstream command bundle and the grant-lock state encoding.
package mem_req_arbiter_pkg;

    localparam logic REQ_ID_INST = 1'b0;
    localparam logic REQ_ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    // One outstanding transaction: who owns the return, and whether to drop it.
    typedef struct packed {
        logic id;
        logic discard;
    } id_entry_t;

    // Request fields carried from a requester to the memory port.
    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Grant lock: idle, or holding the port for one requester until accept.
    typedef enum logic [1:0] {
        LOCK_IDLE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_state_t;

endpackage

// File: rtl/mem_req_arbiter_req_id_fifo.sv
// In-order FIFO of {id, discard} tags for accepted-but-unreturned requests.
// Ports: clk, reset (async, active-high); push/push_entry, pop; mark_inst_discard
// sets discard on every stored inst entry; head, full, empty, count status.
module req_id_fifo
    import mem_req_arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  id_entry_t        push_entry,
    input  logic             pop,
    input  logic             mark_inst_discard,
    output id_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    id_entry_t        slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
    // Marking stale (unoccupied) inst slots is harmless: a push overwrites them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (mark_inst_discard) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (slots[i].id == REQ_ID_INST) begin
                        slots[i].discard <= 1'b1;
                    end
                end
            end
            if (do_push) begin
                slots[wr_ptr] <= push_entry;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// Data has fixed priority; an offered request keeps the grant until accepted.
// Returns are steered by an in-order ID FIFO; cancelled fetch returns are dropped.
// Ports: clk, reset; inst_* and data_* requester handshakes (req/addr_ok/data_ok);
// mem_* downstream port; inst_cancel discards pending fetch returns;
// proto_err flags a return with nothing outstanding (sticky).
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_cancel,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        proto_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    lock_state_t      lock_q;
    lock_state_t      lock_next;
    logic             cancel_lock_q;
    logic             cancel_lock_next;
    logic             gnt_valid;
    logic             gnt_id;
    logic             gnt_req;
    logic             accept;
    logic             ret_valid;
    mem_cmd_t         inst_cmd;
    mem_cmd_t         data_cmd;
    mem_cmd_t         mem_cmd;
    id_entry_t        push_entry;
    id_entry_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign inst_cmd = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                        addr: inst_addr, wdata: inst_wdata};
    assign data_cmd = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                        addr: data_addr, wdata: data_wdata};

    // Grant selection: a held lock wins, otherwise data before inst.
    // Everything is forced quiet while reset is held.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = REQ_ID_INST;
        gnt_req   = 1'b0;
        if (!reset) begin
            if (lock_q == LOCK_INST) begin
                gnt_valid = 1'b1;
                gnt_id    = REQ_ID_INST;
            end else if (lock_q == LOCK_DATA) begin
                gnt_valid = 1'b1;
                gnt_id    = REQ_ID_DATA;
            end else if (data_req) begin
                gnt_valid = 1'b1;
                gnt_id    = REQ_ID_DATA;
            end else if (inst_req) begin
                gnt_valid = 1'b1;
                gnt_id    = REQ_ID_INST;
            end
            gnt_req = gnt_valid & ((gnt_id == REQ_ID_DATA) ? data_req : inst_req);
        end
    end

    always_comb begin
        mem_cmd = '0;
        if (gnt_valid) begin
            mem_cmd = (gnt_id == REQ_ID_DATA) ? data_cmd : inst_cmd;
        end
    end

    assign mem_req   = gnt_req & ~fifo_full;
    assign mem_wr    = mem_cmd.wr;
    assign mem_size  = mem_cmd.size;
    assign mem_wstrb = mem_cmd.wstrb;
    assign mem_addr  = mem_cmd.addr;
    assign mem_wdata = mem_cmd.wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign data_addr_ok = accept & (gnt_id == REQ_ID_DATA);
    assign inst_addr_ok = accept & (gnt_id == REQ_ID_INST);

    // A fetch accepted during or after a cancel is born discarded.
    assign push_entry.id      = gnt_id;
    assign push_entry.discard = (gnt_id == REQ_ID_INST) & (inst_cancel | cancel_lock_q);

    // Return steering from the FIFO head; a return with nothing queued is an error.
    assign ret_valid    = ~reset & mem_data_ok & ~fifo_empty;
    assign data_data_ok = ret_valid & (head.id == REQ_ID_DATA);
    assign inst_data_ok = ret_valid & (head.id == REQ_ID_INST) & ~head.discard;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;

    // Lock and cancel-lock next state.
    always_comb begin
        lock_next        = lock_q;
        cancel_lock_next = cancel_lock_q;
        if (accept) begin
            lock_next = LOCK_IDLE;
        end else if (mem_req) begin
            lock_next = (gnt_id == REQ_ID_DATA) ? LOCK_DATA : LOCK_INST;
        end
        if (accept && (gnt_id == REQ_ID_INST)) begin
            cancel_lock_next = 1'b0;
        end else if (inst_cancel && (lock_q == LOCK_INST) && !accept) begin
            cancel_lock_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q        <= LOCK_IDLE;
            cancel_lock_q <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            lock_q        <= lock_next;
            cancel_lock_q <= cancel_lock_next;
            if (mem_data_ok && (fifo_count == '0)) begin
                proto_err <= 1'b1;
            end
        end
    end

    req_id_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk               (clk),
        .reset             (reset),
        .push              (accept),
        .push_entry        (push_entry),
        .pop               (ret_valid),
        .mark_inst_discard (inst_cancel),
        .head              (head),
        .full              (fifo_full),
        .empty             (fifo_empty),
        .count             (fifo_count)
    );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: priority, locking, full stall,
// cancel handling, protocol error and asynchronous reset.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, inst_cancel;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_cancel  (inst_cancel),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .proto_err    (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hf;
        inst_addr = '0; inst_wdata = '0; inst_cancel = 1'b0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hf;
        data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    endtask

    // Drive point: 1 time unit after the rising edge; checks follow a further #1.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        inst_req = 1'b1; data_req = 1'b1;
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        set_idle();
        next_cycle();
        reset = 1'b0;
        #1;
        chk("idle_mem_req", 32'(mem_req), 32'd0);

        // Simultaneous requests: data first, inst next, in-order returns.
        next_cycle();
        inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        data_req = 1'b1; data_addr = 32'h0000_1000;
        mem_addr_ok = 1'b1;
        #1;
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("t1_inst_addr_ok0", 32'(inst_addr_ok), 32'd0);
        chk("t1_mem_addr_data", mem_addr, 32'h0000_1000);
        next_cycle();
        data_req = 1'b0;
        #1;
        chk("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t1_mem_addr_inst", mem_addr, 32'h1c00_0000);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_aaaa;
        #1;
        chk("t1_data_data_ok", 32'(data_data_ok), 32'd1);
        chk("t1_data_rdata", data_rdata, 32'h0000_aaaa);
        chk("t1_inst_data_ok0", 32'(inst_data_ok), 32'd0);
        next_cycle();
        mem_rdata = 32'h0000_bbbb;
        #1;
        chk("t1_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t1_inst_rdata", inst_rdata, 32'h0000_bbbb);
        chk("t1_data_rdata0", data_rdata, 32'd0);
        next_cycle();
        set_idle();

        // Inst locked for 3 cycles; data raised in cycle 2 must wait.
        inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        #1;
        chk("t2_c1_mem_addr", mem_addr, 32'h1c00_0000);
        next_cycle();
        data_req = 1'b1; data_addr = 32'h0000_1000;
        #1;
        chk("t2_c2_mem_addr", mem_addr, 32'h1c00_0000);
        chk("t2_c2_data_addr_ok", 32'(data_addr_ok), 32'd0);
        next_cycle();
        #1;
        chk("t2_c3_mem_addr", mem_addr, 32'h1c00_0000);
        next_cycle();
        mem_addr_ok = 1'b1;
        #1;
        chk("t2_c4_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t2_c4_data_addr_ok", 32'(data_addr_ok), 32'd0);
        next_cycle();
        inst_req = 1'b0;
        #1;
        chk("t2_c5_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("t2_c5_mem_addr", mem_addr, 32'h0000_1000);
        next_cycle();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'h11;
        #1;
        chk("t2_ret_inst", inst_rdata, 32'h11);
        next_cycle();
        mem_rdata = 32'h22;
        #1;
        chk("t2_ret_data", data_rdata, 32'h22);
        next_cycle();
        set_idle();

        // Full FIFO stalls a third request; pop does not bypass the same cycle.
        inst_req = 1'b1; inst_addr = 32'h100; mem_addr_ok = 1'b1;
        next_cycle();
        inst_addr = 32'h104;
        next_cycle();
        inst_addr = 32'h108;
        mem_data_ok = 1'b1; mem_rdata = 32'h33;
        #1;
        chk("t3_full_mem_req", 32'(mem_req), 32'd0);
        chk("t3_full_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("t3_pop_data_ok", 32'(inst_data_ok), 32'd1);
        next_cycle();
        mem_data_ok = 1'b0;
        #1;
        chk("t3_resume_mem_req", 32'(mem_req), 32'd1);
        chk("t3_resume_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t3_resume_addr", mem_addr, 32'h108);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h34;
        #1;
        chk("t3_drain1", inst_rdata, 32'h34);
        next_cycle();
        mem_rdata = 32'h35;
        #1;
        chk("t3_drain2", inst_rdata, 32'h35);
        next_cycle();
        set_idle();

        // Cancel two outstanding fetches; both returns dropped, later fetch normal.
        inst_req = 1'b1; inst_addr = 32'h200; mem_addr_ok = 1'b1;
        next_cycle();
        inst_addr = 32'h204;
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; inst_cancel = 1'b1;
        next_cycle();
        inst_cancel = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h44;
        #1;
        chk("t4_drop1_ok", 32'(inst_data_ok), 32'd0);
        chk("t4_drop1_rdata", inst_rdata, 32'd0);
        next_cycle();
        #1;
        chk("t4_drop2_ok", 32'(inst_data_ok), 32'd0);
        next_cycle();
        mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h208; mem_addr_ok = 1'b1;
        #1;
        chk("t4_new_addr_ok", 32'(inst_addr_ok), 32'd1);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h5555;
        #1;
        chk("t4_new_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t4_new_rdata", inst_rdata, 32'h5555);
        next_cycle();
        set_idle();

        // Cancel while an inst request is locked; data queued behind returns.
        inst_req = 1'b1; inst_addr = 32'h300;
        #1;
        chk("t5_offer", 32'(mem_req), 32'd1);
        next_cycle();
        inst_cancel = 1'b1;
        #1;
        chk("t5_no_accept", 32'(inst_addr_ok), 32'd0);
        next_cycle();
        inst_cancel = 1'b0;
        next_cycle();
        mem_addr_ok = 1'b1;
        #1;
        chk("t5_accept", 32'(inst_addr_ok), 32'd1);
        next_cycle();
        inst_req = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h2000; data_wdata = 32'hdead;
        #1;
        chk("t5_data_accept", 32'(data_addr_ok), 32'd1);
        chk("t5_mem_wr", 32'(mem_wr), 32'd1);
        chk("t5_mem_wdata", mem_wdata, 32'hdead);
        next_cycle();
        data_req = 1'b0; data_wr = 1'b0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'h66;
        #1;
        chk("t5_drop_inst", 32'(inst_data_ok), 32'd0);
        chk("t5_drop_data", 32'(data_data_ok), 32'd0);
        next_cycle();
        mem_rdata = 32'h77;
        #1;
        chk("t5_data_ok", 32'(data_data_ok), 32'd1);
        chk("t5_data_rdata", data_rdata, 32'h77);
        next_cycle();
        set_idle();

        // Stray return sets proto_err; async reset clears everything.
        mem_data_ok = 1'b1; mem_rdata = 32'h99;
        #1;
        chk("t6_stray_inst_ok", 32'(inst_data_ok), 32'd0);
        chk("t6_stray_data_ok", 32'(data_data_ok), 32'd0);
        next_cycle();
        mem_data_ok = 1'b0;
        #1;
        chk("t6_proto_err", 32'(proto_err), 32'd1);
        next_cycle();
        inst_req = 1'b1; inst_addr = 32'h400; mem_addr_ok = 1'b1;
        next_cycle();
        mem_addr_ok = 1'b0; inst_addr = 32'h404;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_proto_err", 32'(proto_err), 32'd0);
        chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
        chk("t6_rst_mem_addr", mem_addr, 32'd0);
        next_cycle();
        set_idle();
        reset = 1'b0;
        #1;
        chk("t6_post_mem_req", 32'(mem_req), 32'd0);
        next_cycle();
        mem_data_ok = 1'b1; mem_rdata = 32'h12;
        #1;
        chk("t6_dropped_entry", 32'(inst_data_ok), 32'd0);
        next_cycle();
        mem_data_ok = 1'b0;
        #1;
        chk("t6_proto_err_again", 32'(proto_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
